spi_cmd_dispatch: RTL

Byte-level command decoder and response generator directly downstream of the SPI slave front end on the robot FPGA. It consumes received bytes and frame boundaries (chip-select edges), decodes the address byte, and streams back status, encoder deltas or the version number. It also captures motor duty writes and hands them to the motor drivers. All logic runs in the system clock domain. Any SCK-domain work is done in the front end.

---
 rtl/spi_cmd_dispatch_if.sv | 12 +
 rtl/spi_cmd_dispatch.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/spi_cmd_dispatch_if.sv
// Byte-level link between the SPI slave front end (master side) and the command
// dispatcher (slave side). Framing pulses and rx bytes flow in, tx bytes flow out.
interface spi_cmd_dispatch_if;
   logic       frame_start;
   logic       frame_end;
   logic       rx_valid;
   logic [7:0] rx_data;
   logic [7:0] tx_data;

   modport master (output frame_start, frame_end, rx_valid, rx_data, input tx_data);
   modport slave  (input frame_start, frame_end, rx_valid, rx_data, output tx_data);
endinterface

// File: rtl/spi_cmd_dispatch.sv
// SPI command decoder: decodes the address byte of each frame, streams status,
// encoder deltas or version back, and commits motor duty writes on frame end.
module spi_cmd_dispatch #(
   parameter int         NUM_MOTORS = 4,
   parameter int         ENC_WIDTH  = 16,
   parameter int         DUTY_WIDTH = 11,
   parameter logic [7:0] VERSION    = 8'h01
) (
   input  logic                             clk,
   input  logic                             rst_n,
   spi_cmd_dispatch_if.slave                spi,
   input  logic [NUM_MOTORS*ENC_WIDTH-1:0]  enc_count,
   input  logic [4:0]                       fault,
   input  logic                             no_motor_board,
   input  logic                             ready,
   output logic [NUM_MOTORS*DUTY_WIDTH-1:0] duty_out,
   output logic [NUM_MOTORS-1:0]            duty_valid,
   output logic                             cmd_error
);
   localparam logic [7:0] ADDR_ENC      = 8'h00;
   localparam logic [7:0] ADDR_VER      = 8'h05;
   localparam logic [7:0] ADDR_DUTY_MAX = 8'(NUM_MOTORS);
   localparam int         HI_W          = DUTY_WIDTH - 8;
   localparam int         MSEL_W        = $clog2(NUM_MOTORS);

   typedef enum logic [1:0] {IDLE, ADDR, XFER} state_t;

   state_t                       state;
   logic [3:0]                   byte_idx;
   logic [7:0]                   addr_q;
   logic [7:0]                   tx_q;
   logic [7:0]                   duty_lo_q;
   logic [HI_W-1:0]              duty_hi_q;
   logic [ENC_WIDTH-1:0]         last_q    [NUM_MOTORS];
   logic [ENC_WIDTH-1:0]         delta_q   [NUM_MOTORS];
   logic [ENC_WIDTH-1:0]         delta_now [NUM_MOTORS];
   logic signed [DUTY_WIDTH-1:0] duty_q    [NUM_MOTORS];

   function automatic logic [3:0] sat_inc(input logic [3:0] v);
      return (v == 4'hF) ? v : v + 4'd1;
   endfunction

   function automatic logic is_duty(input logic [7:0] a);
      return (a != 8'h00) && (a <= ADDR_DUTY_MAX);
   endfunction

   function automatic logic is_known(input logic [7:0] a);
      return (a == ADDR_ENC) || (a == ADDR_VER) || is_duty(a);
   endfunction

   logic              in_frame, abort, rx_take, decode, end_valid, addr_known;
   logic              commit, short_err;
   logic [3:0]        idx_nxt, pidx;
   logic [7:0]        addr_nxt, lo_nxt, status, payload;
   logic [HI_W-1:0]   hi_nxt;
   logic [MSEL_W-1:0] msel;

   // A byte coincident with frame_end is folded in before the end is judged.
   always_comb begin
      in_frame   = (state != IDLE);
      abort      = spi.frame_start && !spi.frame_end && in_frame;
      rx_take    = spi.rx_valid && in_frame && !abort;
      decode     = rx_take && (state == ADDR);
      idx_nxt    = (rx_take && state == XFER) ? sat_inc(byte_idx) : byte_idx;
      addr_nxt   = decode ? spi.rx_data : addr_q;
      lo_nxt     = (rx_take && state == XFER && byte_idx == 4'd1) ? spi.rx_data : duty_lo_q;
      hi_nxt     = (rx_take && state == XFER && byte_idx == 4'd2) ? spi.rx_data[HI_W-1:0] : duty_hi_q;
      end_valid  = spi.frame_end && in_frame;
      addr_known = (state == XFER) || decode;
      commit     = end_valid && addr_known && is_duty(addr_nxt) && (state == XFER) && (idx_nxt >= 4'd3);
      short_err  = end_valid && addr_known && is_duty(addr_nxt) && !commit;
      status     = {~ready, no_motor_board, 1'b0, fault[4:1], fault[0]};
      for (int m = 0; m < NUM_MOTORS; m++)
         delta_now[m] = enc_count[m*ENC_WIDTH +: ENC_WIDTH] - last_q[m];
      pidx    = decode ? 4'd0 : idx_nxt - 4'd1;
      msel    = pidx[MSEL_W:1];
      payload = 8'h00;
      if (addr_nxt == ADDR_ENC) begin
         if (decode)
            payload = delta_now[0][7:0];
         else if (pidx < 4'(2*NUM_MOTORS))
            payload = pidx[0] ? delta_q[msel][15:8] : delta_q[msel][7:0];
      end else if (addr_nxt == ADDR_VER) begin
         payload = (pidx == 4'd0) ? VERSION : 8'h00;
      end else if (!is_duty(addr_nxt)) begin
         payload = 8'hFF;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         byte_idx   <= 4'd0;
         addr_q     <= 8'h00;
         tx_q       <= 8'hFF;
         cmd_error  <= 1'b0;
         duty_valid <= '0;
         for (int m = 0; m < NUM_MOTORS; m++) begin
            last_q[m] <= '0;
            duty_q[m] <= '0;
         end
      end else begin
         cmd_error  <= (decode && !is_known(spi.rx_data)) || short_err;
         duty_valid <= '0;
         if (decode)
            addr_q <= spi.rx_data;
         for (int m = 0; m < NUM_MOTORS; m++) begin
            if (decode && spi.rx_data == ADDR_ENC)
               last_q[m] <= enc_count[m*ENC_WIDTH +: ENC_WIDTH];
            if (commit && addr_nxt == 8'(m + 1)) begin
               duty_q[m]     <= $signed({hi_nxt, lo_nxt});
               duty_valid[m] <= 1'b1;
            end
         end
         // frame_start wins last so an end+start pair lands in ADDR with status loaded.
         if (spi.frame_start) begin
            state    <= ADDR;
            byte_idx <= 4'd0;
            tx_q     <= status;
         end else if (spi.frame_end) begin
            state <= IDLE;
            tx_q  <= 8'hFF;
         end else if (rx_take) begin
            if (state == ADDR) begin
               state    <= XFER;
               byte_idx <= 4'd1;
            end else begin
               byte_idx <= idx_nxt;
            end
            tx_q <= payload;
         end
      end
   end

   // Payload holding registers; only ever read after a decode has refreshed them.
   always_ff @(posedge clk) begin
      duty_lo_q <= lo_nxt;
      duty_hi_q <= hi_nxt;
      for (int m = 0; m < NUM_MOTORS; m++)
         if (decode && spi.rx_data == ADDR_ENC)
            delta_q[m] <= delta_now[m];
   end

   assign spi.tx_data = tx_q;

   for (genvar g = 0; g < NUM_MOTORS; g++) begin : g_duty
      assign duty_out[g*DUTY_WIDTH +: DUTY_WIDTH] = duty_q[g];
   end
endmodule
